// File: rtl/bcd_serial_receiver.sv
// Hunts a serial stream for SYNC_WORD, captures a 16-bit packed BCD payload and converts it to binary.
// Define BCD_RX_PARITY_EN to require a trailing even-parity bit and expose out_parity_err.
module bcd_serial_receiver #(
  parameter logic [7:0] SYNC_WORD = 8'b10010110,
  parameter int         DATA_BITS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        serial_in,
  input  logic        bit_valid,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] out_bcd,
  output logic [13:0] out_bin,
  output logic        out_digit_err,
`ifdef BCD_RX_PARITY_EN
  output logic        out_parity_err,
`endif
  output logic        overrun,
  output logic        busy
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    DATA   = 2'd1,
`ifdef BCD_RX_PARITY_EN
    PARITY = 2'd2,
`endif
    DONE   = 2'd3
  } state_t;

  state_t      state_q;
  logic [7:0]  hunt_sr_q;
  logic [15:0] data_sr_q;
  logic [3:0]  bit_cnt_q;
  logic        out_valid_q;
  logic [15:0] out_bcd_q;
  logic [13:0] out_bin_q;
  logic        out_digit_err_q;
  logic        overrun_q;
`ifdef BCD_RX_PARITY_EN
  logic        parity_bit_q;
  logic        out_parity_err_q;
  logic        parity_err_d;
`endif

  logic [7:0]  hunt_d;
  logic [15:0] data_d;
  logic        digit_err_d;
  logic [13:0] bin_d;
  logic        accept_d;

  always_comb begin
    hunt_d      = {hunt_sr_q[6:0], serial_in};
    data_d      = {data_sr_q[14:0], serial_in};
    digit_err_d = (data_sr_q[15:12] > 4'd9) || (data_sr_q[11:8] > 4'd9) ||
                  (data_sr_q[7:4]   > 4'd9) || (data_sr_q[3:0]  > 4'd9);
    // Overflows only for invalid digits, which are forced to zero on load.
    bin_d       = 14'(data_sr_q[15:12]) * 14'd1000 + 14'(data_sr_q[11:8]) * 14'd100 +
                  14'(data_sr_q[7:4])   * 14'd10   + 14'(data_sr_q[3:0]);
    accept_d    = !out_valid_q || out_ready;
`ifdef BCD_RX_PARITY_EN
    parity_err_d = ^{data_sr_q, parity_bit_q};
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= HUNT;
      hunt_sr_q       <= '0;
      data_sr_q       <= '0;
      bit_cnt_q       <= '0;
      out_valid_q     <= 1'b0;
      out_bcd_q       <= '0;
      out_bin_q       <= '0;
      out_digit_err_q <= 1'b0;
      overrun_q       <= 1'b0;
`ifdef BCD_RX_PARITY_EN
      parity_bit_q     <= 1'b0;
      out_parity_err_q <= 1'b0;
`endif
    end else begin
      overrun_q <= 1'b0;
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        HUNT: begin
          if (bit_valid) begin
            if (hunt_d == SYNC_WORD) begin
              state_q   <= DATA;
              hunt_sr_q <= '0;
              bit_cnt_q <= '0;
            end else begin
              hunt_sr_q <= hunt_d;
            end
          end
        end
        DATA: begin
          if (bit_valid) begin
            data_sr_q <= data_d;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == LAST_BIT) begin
`ifdef BCD_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= DONE;
`endif
            end
          end
        end
`ifdef BCD_RX_PARITY_EN
        PARITY: begin
          if (bit_valid) begin
            parity_bit_q <= serial_in;
            state_q      <= DONE;
          end
        end
`endif
        DONE: begin
          // A load in the same cycle as a consume keeps out_valid high with the new word.
          if (accept_d) begin
            out_valid_q     <= 1'b1;
            out_bcd_q       <= data_sr_q;
            out_digit_err_q <= digit_err_d;
            out_bin_q       <= digit_err_d ? 14'd0 : bin_d;
`ifdef BCD_RX_PARITY_EN
            out_parity_err_q <= parity_err_d;
`endif
          end else begin
            overrun_q <= 1'b1;
          end
          state_q   <= HUNT;
          hunt_sr_q <= '0;
        end
        default: state_q <= HUNT;
      endcase
    end
  end

  assign out_valid     = out_valid_q;
  assign out_bcd       = out_bcd_q;
  assign out_bin       = out_bin_q;
  assign out_digit_err = out_digit_err_q;
  assign overrun       = overrun_q;
  assign busy          = (state_q != HUNT);
`ifdef BCD_RX_PARITY_EN
  assign out_parity_err = out_parity_err_q;
`endif

endmodule

// File: tb/tb_bcd_serial_receiver.sv
// Self-checking bench for bcd_serial_receiver: directed frames plus randomized frames against a decimal model.
// Honours BCD_RX_PARITY_EN when defined (adds the parity bit and the parity check).
module tb_bcd_serial_receiver;

  localparam logic [7:0] SYNC = 8'b10010110;

  logic        clk = 1'b0;
  logic        reset;
  logic        serial_in;
  logic        bit_valid;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_bcd;
  logic [13:0] out_bin;
  logic        out_digit_err;
  logic        overrun;
  logic        busy;
`ifdef BCD_RX_PARITY_EN
  logic        out_parity_err;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] gotBcd[$];
  logic [13:0] gotBin[$];
  logic        gotErr[$];
  int          overrunCount = 0;

  bcd_serial_receiver dut (
    .clk           (clk),
    .reset         (reset),
    .serial_in     (serial_in),
    .bit_valid     (bit_valid),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_bcd       (out_bcd),
    .out_bin       (out_bin),
    .out_digit_err (out_digit_err),
`ifdef BCD_RX_PARITY_EN
    .out_parity_err(out_parity_err),
`endif
    .overrun       (overrun),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Scoreboard capture: every handshaken word, and every overrun pulse.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      gotBcd.push_back(out_bcd);
      gotBin.push_back(out_bin);
      gotErr.push_back(out_digit_err);
    end
    if (overrun) overrunCount++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sendBit(input logic b, input bit gaps);
    if (gaps && $urandom_range(0, 3) == 0) begin
      bit_valid = 1'b0;
      serial_in = 1'($urandom);
      tick();
    end
    serial_in = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] word, input bit gaps, input bit flipParity);
    for (int i = 7; i >= 0; i--) sendBit(SYNC[i], gaps);
    for (int i = 15; i >= 0; i--) sendBit(word[i], gaps);
`ifdef BCD_RX_PARITY_EN
    sendBit((^word) ^ flipParity, gaps);
`else
    if (flipParity) tick();
`endif
  endtask

  task automatic waitOutputs(input string tag, input int target);
    for (int c = 0; c < 40 && gotBcd.size() < target; c++) tick();
    checkOutput(tag, 32'(gotBcd.size() >= target), 32'd1);
  endtask

  // Reference model: build BCD from a decimal number so the expected binary is the number itself.
  function automatic logic [15:0] toBcd(input int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  initial begin
    int mark;
    int ovMark;
    reset     = 1'b1;
    serial_in = 1'b0;
    bit_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_bcd", 32'(out_bcd), 32'd0);
    checkOutput("rst_bin", 32'(out_bin), 32'd0);
    checkOutput("rst_err", 32'(out_digit_err), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();

    // Basic frame and output latency.
    applyStimulus(16'h1234, 1'b0, 1'b0);
    checkOutput("lat_early_valid", 32'(out_valid), 32'd0);
    checkOutput("lat_done_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("f1234_valid", 32'(out_valid), 32'd1);
    checkOutput("f1234_bcd", 32'(out_bcd), 32'h1234);
    checkOutput("f1234_bin", 32'(out_bin), 32'd1234);
    checkOutput("f1234_err", 32'(out_digit_err), 32'd0);
    checkOutput("f1234_busy", 32'(busy), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("f1234_consumed", 32'(out_valid), 32'd0);

    // Invalid digit.
    applyStimulus(16'h9A05, 1'b0, 1'b0);
    tick();
    checkOutput("f9A05_valid", 32'(out_valid), 32'd1);
    checkOutput("f9A05_bcd", 32'(out_bcd), 32'h9A05);
    checkOutput("f9A05_bin", 32'(out_bin), 32'd0);
    checkOutput("f9A05_err", 32'(out_digit_err), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("f9A05_consumed", 32'(out_valid), 32'd0);

    // Back-to-back frames with a full output register.
    ovMark = overrunCount;
    applyStimulus(16'h0042, 1'b0, 1'b0);
    tick();
    applyStimulus(16'h0777, 1'b0, 1'b0);
    checkOutput("b2b_ov_before", 32'(overrun), 32'd0);
    tick();
    checkOutput("b2b_overrun", 32'(overrun), 32'd1);
    checkOutput("b2b_held_bcd", 32'(out_bcd), 32'h0042);
    checkOutput("b2b_held_bin", 32'(out_bin), 32'd42);
    checkOutput("b2b_held_valid", 32'(out_valid), 32'd1);
    tick();
    checkOutput("b2b_ov_pulse", 32'(overrun), 32'd0);
    checkOutput("b2b_ov_count", 32'(overrunCount - ovMark), 32'd1);
    out_ready = 1'b1;
    tick();
    checkOutput("b2b_consumed", 32'(out_valid), 32'd0);

    // Sync pattern inside the payload must not retrigger.
    mark = gotBcd.size();
    applyStimulus(16'h9696, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) sendBit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("f9696_count", 32'(gotBcd.size() - mark), 32'd1);
    if (gotBcd.size() > mark) checkOutput("f9696_bcd", 32'(gotBcd[mark]), 32'h9696);

    // Reset in the middle of a payload aborts it cleanly.
    mark   = gotBcd.size();
    ovMark = overrunCount;
    for (int i = 7; i >= 0; i--) sendBit(SYNC[i], 1'b0);
    for (int i = 0; i < 8; i++) sendBit(i[0] ? 1'b1 : 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    applyStimulus(16'h0001, 1'b0, 1'b0);
    waitOutputs("midrst_wait", mark + 1);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("midrst_count", 32'(gotBcd.size() - mark), 32'd1);
    checkOutput("midrst_overrun", 32'(overrunCount - ovMark), 32'd0);
    if (gotBcd.size() > mark) begin
      checkOutput("midrst_bcd", 32'(gotBcd[mark]), 32'h0001);
      checkOutput("midrst_bin", 32'(gotBin[mark]), 32'd1);
    end

`ifdef BCD_RX_PARITY_EN
    out_ready = 1'b0;
    applyStimulus(16'h0003, 1'b0, 1'b1);
    tick();
    checkOutput("par_bad", 32'(out_parity_err), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    applyStimulus(16'h0003, 1'b0, 1'b0);
    tick();
    checkOutput("par_good", 32'(out_parity_err), 32'd0);
    out_ready = 1'b1;
    tick();
`endif

    // Randomized frames with bit_valid gaps against the decimal model.
    out_ready = 1'b1;
    for (int f = 0; f < 20; f++) begin
      int          n;
      logic [15:0] word;
      logic [13:0] expBin;
      logic        expErr;
      n      = int'($urandom_range(0, 9999));
      word   = toBcd(n);
      expBin = 14'(n);
      expErr = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        int pos;
        pos = int'($urandom_range(0, 3));
        word[pos*4 +: 4] = 4'($urandom_range(10, 15));
        expBin = 14'd0;
        expErr = 1'b1;
      end
      mark = gotBcd.size();
      applyStimulus(word, 1'b1, 1'b0);
      waitOutputs("rnd_wait", mark + 1);
      if (gotBcd.size() > mark) begin
        checkOutput("rnd_bcd", 32'(gotBcd[mark]), 32'(word));
        checkOutput("rnd_bin", 32'(gotBin[mark]), 32'(expBin));
        checkOutput("rnd_err", 32'(gotErr[mark]), 32'(expErr));
      end
      tick();
    end
    checkOutput("rnd_no_overrun", 32'(overrun), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
